// File: rtl/iir_coeff_loader_pkg.sv
// -----------------------------------------------------------------------------
// iir_coeff_loader_pkg
// Shared filter definitions: coefficient format (sfix15_En11), section sizes,
// the fixed default coefficient set and the loader FSM state encoding.
// -----------------------------------------------------------------------------
package iir_coeff_loader_pkg;

    localparam int CW = 15;   // coefficient width, signed, 11 fractional bits
    localparam int NA = 6;    // feedback (a) coefficient count
    localparam int NB = 6;    // feed-forward (b) coefficient count

    typedef logic signed [CW-1:0] coeff_t;

    // Fixed coefficient set; 1.0 == 2048 in sfix15_En11.
    localparam coeff_t DEFAULT_A [NA] = '{
        15'sd2048, -15'sd3686, 15'sd3317, -15'sd1638, 15'sd430, -15'sd47
    };
    localparam coeff_t DEFAULT_B [NB] = '{
        15'sd3, 15'sd16, 15'sd33, 15'sd33, 15'sd16, 15'sd3
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    // Default lookups that stay in range when a module is built with more
    // coefficients than the fixed set provides (extra entries reset to zero).
    function automatic coeff_t default_a(input int i);
        coeff_t c;
        c = '0;
        for (int k = 0; k < NA; k++) begin
            if (k == i) c = DEFAULT_A[k];
        end
        return c;
    endfunction

    function automatic coeff_t default_b(input int i);
        coeff_t c;
        c = '0;
        for (int k = 0; k < NB; k++) begin
            if (k == i) c = DEFAULT_B[k];
        end
        return c;
    endfunction

endpackage

// File: rtl/iir_coeff_loader_if.sv
// -----------------------------------------------------------------------------
// iir_coeff_loader_if
// Coefficient write stream: valid/ready handshake carrying one signed
// coefficient word per transfer plus an end-of-frame marker.
//   wr_valid : word on wr_data is valid          (master -> slave)
//   wr_data  : coefficient word, DW bits          (master -> slave)
//   wr_last  : final word of a frame              (master -> slave)
//   wr_ready : slave accepts a word this cycle    (slave -> master)
// -----------------------------------------------------------------------------
interface iir_coeff_loader_if #(
    parameter int DW = iir_coeff_loader_pkg::CW
);
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          wr_ready;

    modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/iir_coeff_loader_coeff_bank.sv
// -----------------------------------------------------------------------------
// iir_coeff_loader_coeff_bank
// Shadow coefficient store written one word at a time, and the active
// coefficient registers that take a full copy of the shadow on commit_en.
//   clk, reset : clock, synchronous active-high reset (active -> defaults)
//   wr_en      : write wr_data into shadow[wr_idx]
//   wr_idx     : shadow index, a[0..NA-1] then b[0..NB-1]
//   wr_data    : coefficient word
//   commit_en  : copy the whole shadow into the active registers
//   a_c, b_c   : active coefficients
// -----------------------------------------------------------------------------
module iir_coeff_loader_coeff_bank #(
    parameter int NA = iir_coeff_loader_pkg::NA,
    parameter int NB = iir_coeff_loader_pkg::NB,
    parameter int CW = iir_coeff_loader_pkg::CW,
    parameter int IW = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [IW-1:0]          wr_idx,
    input  logic [CW-1:0]          wr_data,
    input  logic                   commit_en,
    output logic [NA-1:0][CW-1:0]  a_c,
    output logic [NB-1:0][CW-1:0]  b_c
);
    import iir_coeff_loader_pkg::*;

    localparam int N = NA + NB;

    // Shadow contents are don't-care after reset, so no reset branch.
    logic [CW-1:0] shadow_reg [N];
    logic [CW-1:0] a_active_reg [NA];
    logic [CW-1:0] b_active_reg [NB];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            shadow_reg[wr_idx] <= wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NA; gi++) begin : g_a
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_active_reg[gi] <= CW'(default_a(gi));
                end else if (commit_en) begin
                    a_active_reg[gi] <= shadow_reg[gi];
                end
            end
            assign a_c[gi] = a_active_reg[gi];
        end

        for (genvar gi = 0; gi < NB; gi++) begin : g_b
            always_ff @(posedge clk) begin
                if (reset) begin
                    b_active_reg[gi] <= CW'(default_b(gi));
                end else if (commit_en) begin
                    b_active_reg[gi] <= shadow_reg[NA + gi];
                end
            end
            assign b_c[gi] = b_active_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/iir_coeff_loader.sv
// -----------------------------------------------------------------------------
// iir_coeff_loader
// Loads a frame of NA+NB coefficients into a shadow bank and, once the frame
// is complete and well formed, swaps the whole set into the active registers
// on the next sample strobe so the filter never sees a half-updated set.
//   clk, reset : clock, synchronous active-high reset
//   wr         : coefficient write stream (slave side)
//   sample_en  : filter sample strobe; the only moment a commit may happen
//   a_c, b_c   : active feedback / feed-forward coefficients
//   commit     : one-cycle pulse, active set updated
//   load_err   : one-cycle pulse, malformed frame discarded
//   busy       : frame in progress or waiting for commit
// -----------------------------------------------------------------------------
module iir_coeff_loader #(
    parameter int NA = iir_coeff_loader_pkg::NA,
    parameter int NB = iir_coeff_loader_pkg::NB,
    parameter int CW = iir_coeff_loader_pkg::CW
) (
    input  logic                   clk,
    input  logic                   reset,
    iir_coeff_loader_if.slave      wr,
    input  logic                   sample_en,
    output logic [NA-1:0][CW-1:0]  a_c,
    output logic [NB-1:0][CW-1:0]  b_c,
    output logic                   commit,
    output logic                   load_err,
    output logic                   busy
);
    import iir_coeff_loader_pkg::*;

    localparam int N  = NA + NB;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic          commit_reg, commit_next;
    logic          load_err_reg, load_err_next;
    logic          ready;
    logic          accept;
    logic          commit_en;

    // Ready is held low while reset is applied, not just after it.
    assign ready       = ~reset & (state_reg != ST_PENDING);
    assign wr.wr_ready = ready;
    assign accept      = wr.wr_valid & ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            commit_reg   <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            commit_reg   <= commit_next;
            load_err_reg <= load_err_next;
        end
    end

    // idx is always 0 in IDLE, so IDLE and LOAD share the same accept path;
    // this also covers the single-word-frame case.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        commit_next   = 1'b0;
        load_err_next = 1'b0;
        commit_en     = 1'b0;
        case (state_reg)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    if (idx_reg == LAST_IDX) begin
                        idx_next = '0;
                        if (wr.wr_last) begin
                            state_next = ST_PENDING;
                        end else begin
                            state_next    = ST_IDLE;
                            load_err_next = 1'b1;
                        end
                    end else if (wr.wr_last) begin
                        idx_next      = '0;
                        state_next    = ST_IDLE;
                        load_err_next = 1'b1;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_PENDING: begin
                if (sample_en) begin
                    commit_en   = 1'b1;
                    commit_next = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    assign commit   = commit_reg;
    assign load_err = load_err_reg;
    assign busy     = (state_reg != ST_IDLE);

    iir_coeff_loader_coeff_bank #(
        .NA (NA),
        .NB (NB),
        .CW (CW),
        .IW (IW)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (accept),
        .wr_idx    (idx_reg),
        .wr_data   (wr.wr_data),
        .commit_en (commit_en),
        .a_c       (a_c),
        .b_c       (b_c)
    );

endmodule

// File: tb/tb_iir_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_iir_coeff_loader
// Directed self-checking bench for iir_coeff_loader (NA=NB=6, CW=15).
// -----------------------------------------------------------------------------
module tb_iir_coeff_loader;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_en;
    logic [5:0][14:0]  a_c;
    logic [5:0][14:0]  b_c;
    logic              commit;
    logic              load_err;
    logic              busy;

    iir_coeff_loader_if #(.DW(15)) wr_if ();

    iir_coeff_loader dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr_if),
        .sample_en (sample_en),
        .a_c       (a_c),
        .b_c       (b_c),
        .commit    (commit),
        .load_err  (load_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [5:0][14:0] def_a, def_b, exp_a, exp_b;
    logic [14:0]      frame [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive frame[0..count-1] back to back, wr_last on index last_at.
    task automatic send_words(input int count, input int last_at);
        for (int i = 0; i < count; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = frame[i];
            wr_if.wr_last  = (i == last_at);
            tick();
        end
        wr_if.wr_valid = 1'b0;
        wr_if.wr_last  = 1'b0;
    endtask

    task automatic frame_to_exp();
        for (int i = 0; i < 6; i++) begin
            exp_a[i] = frame[i];
            exp_b[i] = frame[6 + i];
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", wr_if.wr_ready); end
        reset = 1'b0;
        tick();
        checks++; if (a_c !== def_a) begin errors++; $display("FAIL reset_a_c: got %h expected %h", a_c, def_a); end
        checks++; if (b_c !== def_b) begin errors++; $display("FAIL reset_b_c: got %h expected %h", b_c, def_b); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b expected 0", commit); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b expected 0", load_err); end
        checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", wr_if.wr_ready); end
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) frame[i] = 15'(i + 1);
        frame_to_exp();
        send_words(12, 11);
        for (int k = 0; k < 5; k++) begin
            checks++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL pend_ready[%0d]: got %b expected 0", k, wr_if.wr_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pend_busy[%0d]: got %b expected 1", k, busy); end
            checks++; if (commit !== 1'b0) begin errors++; $display("FAIL pend_commit[%0d]: got %b expected 0", k, commit); end
            tick();
        end
        sample_en = 1'b1;
        checks++; if (a_c !== def_a) begin errors++; $display("FAIL pre_commit_a_c: got %h expected %h", a_c, def_a); end
        tick();
        sample_en = 1'b0;
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL b2b_commit: got %b expected 1", commit); end
        checks++; if (a_c !== exp_a) begin errors++; $display("FAIL b2b_a_c: got %h expected %h", a_c, exp_a); end
        checks++; if (b_c !== exp_b) begin errors++; $display("FAIL b2b_b_c: got %h expected %h", b_c, exp_b); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b expected 0", busy); end
        tick();
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL b2b_commit_pulse: got %b expected 0", commit); end
        checks++; if (a_c !== exp_a) begin errors++; $display("FAIL b2b_a_hold: got %h expected %h", a_c, exp_a); end
        $display("test_back_to_back done");
    endtask

    task automatic test_malformed();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) frame[i] = 15'h0100 + 15'(i);
        send_words(7, 6);
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL early_last_err: got %b expected 1", load_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL early_last_busy: got %b expected 0", busy); end
        tick();
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL early_last_pulse: got %b expected 0", load_err); end
        checks++; if (a_c !== def_a) begin errors++; $display("FAIL early_last_a_c: got %h expected %h", a_c, def_a); end
        checks++; if (b_c !== def_b) begin errors++; $display("FAIL early_last_b_c: got %h expected %h", b_c, def_b); end
        send_words(12, -1);
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL missing_last_err: got %b expected 1", load_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL missing_last_busy: got %b expected 0", busy); end
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL missing_last_commit: got %b expected 0", commit); end
        checks++; if (a_c !== def_a) begin errors++; $display("FAIL missing_last_a_c: got %h expected %h", a_c, def_a); end
        for (int i = 0; i < 12; i++) frame[i] = 15'h0200 + 15'(i);
        frame_to_exp();
        send_words(12, 11);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL recover_busy: got %b expected 1", busy); end
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL recover_commit: got %b expected 1", commit); end
        checks++; if (a_c !== exp_a) begin errors++; $display("FAIL recover_a_c: got %h expected %h", a_c, exp_a); end
        checks++; if (b_c !== exp_b) begin errors++; $display("FAIL recover_b_c: got %h expected %h", b_c, exp_b); end
        $display("test_malformed done");
    endtask

    task automatic test_sample_en_held();
        logic [5:0][14:0] prev_a;
        prev_a = a_c;
        for (int i = 0; i < 12; i++) frame[i] = 15'h0300 + 15'(i);
        sample_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = frame[i];
            wr_if.wr_last  = (i == 11);
            tick();
            checks++; if (commit !== 1'b0) begin errors++; $display("FAIL held_load_commit[%0d]: got %b expected 0", i, commit); end
        end
        wr_if.wr_valid = 1'b0;
        wr_if.wr_last  = 1'b0;
        checks++; if (a_c !== prev_a) begin errors++; $display("FAIL held_last_a_c: got %h expected %h", a_c, prev_a); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_busy: got %b expected 1", busy); end
        frame_to_exp();
        tick();
        sample_en = 1'b0;
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL held_commit: got %b expected 1", commit); end
        checks++; if (a_c !== exp_a) begin errors++; $display("FAIL held_a_c: got %h expected %h", a_c, exp_a); end
        checks++; if (b_c !== exp_b) begin errors++; $display("FAIL held_b_c: got %h expected %h", b_c, exp_b); end
        tick();
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL held_commit_pulse: got %b expected 0", commit); end
        $display("test_sample_en_held done");
    endtask

    task automatic test_reset_pending();
        for (int i = 0; i < 12; i++) frame[i] = 15'h7FFF;
        send_words(12, 11);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstpend_busy: got %b expected 1", busy); end
        reset = 1'b1;
        sample_en = 1'b1;
        tick();
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL rstpend_commit_in_reset: got %b expected 0", commit); end
        reset = 1'b0;
        tick();
        sample_en = 1'b0;
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL rstpend_commit: got %b expected 0", commit); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstpend_busy_after: got %b expected 0", busy); end
        checks++; if (a_c !== def_a) begin errors++; $display("FAIL rstpend_a_c: got %h expected %h", a_c, def_a); end
        checks++; if (b_c !== def_b) begin errors++; $display("FAIL rstpend_b_c: got %h expected %h", b_c, def_b); end
        $display("test_reset_pending done");
    endtask

    task automatic test_toggle_valid();
        int n;
        int cycles;
        int v;
        for (int i = 0; i < 12; i++) frame[i] = (i % 2 == 1) ? (15'h6000 + 15'(i)) : 15'h4000;
        frame_to_exp();
        n = 0;
        cycles = 0;
        while (n < 12 && cycles < 200) begin
            v = $urandom_range(0, 1);
            if (v == 1) begin
                wr_if.wr_valid = 1'b1;
                wr_if.wr_data  = frame[n];
                wr_if.wr_last  = (n == 11);
                checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL toggle_ready[%0d]: got %b expected 1", n, wr_if.wr_ready); end
            end else begin
                // Garbage on idle cycles must be ignored.
                wr_if.wr_valid = 1'b0;
                wr_if.wr_data  = 15'h1234;
                wr_if.wr_last  = 1'b1;
            end
            tick();
            if (v == 1) n++;
            cycles++;
            checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL toggle_load_err[%0d]: got %b expected 0", cycles, load_err); end
        end
        wr_if.wr_valid = 1'b0;
        wr_if.wr_last  = 1'b0;
        checks++; if (n != 12) begin errors++; $display("FAIL toggle_timeout: got %0d words expected 12", n); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL toggle_busy: got %b expected 1", busy); end
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL toggle_commit: got %b expected 1", commit); end
        checks++; if (a_c !== exp_a) begin errors++; $display("FAIL toggle_a_c: got %h expected %h", a_c, exp_a); end
        checks++; if (b_c !== exp_b) begin errors++; $display("FAIL toggle_b_c: got %h expected %h", b_c, exp_b); end
        checks++; if (b_c[5][14] !== 1'b1) begin errors++; $display("FAIL toggle_sign: got %b expected 1", b_c[5][14]); end
        $display("test_toggle_valid done");
    endtask

    initial begin
        reset          = 1'b1;
        sample_en      = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        wr_if.wr_last  = 1'b0;
        def_a[0] = 15'd2048;    def_a[1] = -15'sd3686; def_a[2] = 15'd3317;
        def_a[3] = -15'sd1638;  def_a[4] = 15'd430;    def_a[5] = -15'sd47;
        def_b[0] = 15'd3;  def_b[1] = 15'd16; def_b[2] = 15'd33;
        def_b[3] = 15'd33; def_b[4] = 15'd16; def_b[5] = 15'd3;
        exp_a = '0;
        exp_b = '0;

        test_reset();
        test_back_to_back();
        test_malformed();
        test_sample_en_held();
        test_reset_pending();
        test_toggle_valid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
